pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 134 +++++++++++++
 tb/tb_pc_fetch.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding memory read, branch redirect with kill of the in-flight read.
// Optional macro IF_INST_BUF_EN: a stalled DONE keeps the fetched word instead of refetching it.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        ex_b_flag,
    input  logic [31:0] ex_b_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_stallreq
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] inst_buf, inst_buf_d;
    logic [31:0] addr_q, addr_d;
    logic        kill, kill_d;

    // Only stall[0] concerns this stage; the other bits belong to later pipeline registers.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    function automatic logic [31:0] align_target(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pc_incr(input logic [31:0] p);
        return p + 32'd4;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inst_buf <= '0;
            kill     <= 1'b0;
            addr_q   <= RESET_PC;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            inst_buf <= inst_buf_d;
            kill     <= kill_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        inst_buf_d  = inst_buf;
        kill_d      = kill;
        addr_d      = addr_q;
        mem_req     = 1'b0;
        mem_addr    = addr_q;
        if_pc       = pc;
        if_inst     = '0;
        if_stallreq = 1'b1;

        case (state)
            IDLE: begin
                if (ex_b_flag) begin
                    pc_d = align_target(ex_b_target);
                end
                state_d = REQ;
                addr_d  = pc_d;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (kill || ex_b_flag) begin
                        // Returned word belongs to the abandoned path: drop it and reissue at pc.
                        if (ex_b_flag) begin
                            pc_d = align_target(ex_b_target);
                        end
                        kill_d = 1'b0;
                        addr_d = pc_d;
                    end else begin
                        inst_buf_d = mem_rdata;
                        state_d    = DONE;
                    end
                end else if (ex_b_flag) begin
                    // The read in flight cannot be cancelled; mem_addr holds until its ack.
                    pc_d   = align_target(ex_b_target);
                    kill_d = 1'b1;
                end
            end
            DONE: begin
                if_stallreq = 1'b0;
                if_inst     = inst_buf;
                if (ex_b_flag) begin
                    pc_d    = align_target(ex_b_target);
                    state_d = REQ;
                    addr_d  = pc_d;
                end else if (!stall[0]) begin
                    pc_d    = pc_incr(pc);
                    state_d = REQ;
                    addr_d  = pc_d;
                end else begin
`ifdef IF_INST_BUF_EN
                    state_d = DONE;
`else
                    inst_buf_d = '0;
                    state_d    = REQ;
                    addr_d     = pc;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset takes effect on the outputs in the same cycle it is raised.
        if (rst) begin
            mem_req     = 1'b0;
            mem_addr    = RESET_PC;
            if_pc       = RESET_PC;
            if_inst     = '0;
            if_stallreq = 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: memory model with variable ack latency, program-order reference model.
module tb_pc_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_b_flag;
    logic [31:0] ex_b_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stallreq;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          stray_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = RESET_PC;
    logic [31:0] iss_q[$];
    int          acc_cyc[$];

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .ex_b_flag   (ex_b_flag),
        .ex_b_target (ex_b_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_stallreq (if_stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents: distinct per word address and never the bubble value.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        if (i < 0 || i >= iss_q.size()) return 32'hDEAD_DEAD;
        return iss_q[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout, required DUT event", name);
    endtask

    // Advance one clock; the reference model then folds in what the cycle just completed did:
    // reset restarts the stream, a branch restarts it at the aligned target, an accept moves on by 4.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            last_pc = RESET_PC;
            exp_q.push_back(last_pc);
        end else if (ex_b_flag) begin
            exp_q.delete();
            last_pc = ex_b_target & ~32'h3;
            exp_q.push_back(last_pc);
        end else if (exp_q.size() == 0) begin
            last_pc = last_pc + 32'd4;
            exp_q.push_back(last_pc);
        end
    endtask

    task automatic wait_new_issue(input string name);
        int n0;
        n0 = iss_q.size();
        for (int i = 0; i < 30 && iss_q.size() <= n0; i++) tick();
        if (iss_q.size() <= n0) fail_now(name);
    endtask

    // Memory model: random latency, checks the request is held and its address stable.
    initial begin
        bit          busy;
        int          remain;
        logic [31:0] cur_addr;
        busy = 1'b0;
        remain = 0;
        cur_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (rst === 1'b1) begin
                busy = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (!busy) begin
                    busy = 1'b1;
                    cur_addr = mem_addr;
                    remain = int'($urandom_range(lat_max, lat_min));
                    iss_q.push_back(mem_addr);
                end else begin
                    check("addr_stable", mem_addr, cur_addr);
                end
                remain--;
                if (remain <= 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(cur_addr);
                    busy = 1'b0;
                end
            end else begin
                if (busy) begin
                    check("req_held", 32'(mem_req), 32'd1);
                    busy = 1'b0;
                end
                if (stray_ack) begin
                    mem_ack = 1'b1;
                    mem_rdata = 32'hDEAD_BEEF;
                    stray_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: an instruction is taken whenever fetch is ready and the PC is not held.
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (mem_req === 1'b1) begin
                    check("req_view", {if_stallreq, if_inst[30:0]}, 32'h8000_0000);
                    check("req_inst_bubble", if_inst, 32'd0);
                end
                if (if_stallreq === 1'b0) begin
                    check("done_no_req", 32'(mem_req), 32'd0);
                    if (stall[0] === 1'b0) begin
                        n_acc++;
                        acc_cyc.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            fail_now("accept_unexpected");
                        end else begin
                            p = exp_q.pop_front();
                            check("accept_pc", if_pc, p);
                            check("accept_inst", if_inst, mem_word(p));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        int          n0;
        int          found;
        int          acc0;

        rst = 1'b1;
        stall = '0;
        ex_b_flag = 1'b0;
        ex_b_target = '0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_stallreq", 32'(if_stallreq), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, RESET_PC);

        // Single-cycle memory, no stalls: sequential addresses, one word per two cycles
        repeat (8) tick();
        check("seq_addr0", iss_at(0), 32'h0);
        check("seq_addr1", iss_at(1), 32'h4);
        check("seq_addr2", iss_at(2), 32'h8);
        if (acc_cyc.size() >= 3) begin
            check("rate_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
            check("rate_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
        end else begin
            fail_now("rate_accepts");
        end

        // Three-cycle memory: request held with constant address
        lat_min = 3;
        lat_max = 3;
        wait_new_issue("lat3_issue");
        n0 = iss_q.size() - 1;
        @(negedge clk);
        check("lat3_req_c2", 32'(mem_req), 32'd1);
        tick();
        @(negedge clk);
        check("lat3_req_c3", 32'(mem_req), 32'd1);
        check("lat3_addr_c3", mem_addr, iss_at(n0));
        tick();
        @(negedge clk);
        check("lat3_done", 32'(if_stallreq), 32'd0);
        check("lat3_done_inst", if_inst, mem_word(iss_at(n0)));

        // Branch to an unaligned target while a read is in flight
        wait_new_issue("br_issue");
        n0 = iss_q.size();
        ex_b_flag = 1'b1;
        ex_b_target = 32'h0000_0103;
        tick();
        ex_b_flag = 1'b0;
        for (int i = 0; i < 30 && iss_q.size() <= n0; i++) tick();
        check("br_redirect_addr", iss_at(n0), 32'h0000_0100);

        // Stall held in DONE for four cycles
        lat_min = 1;
        lat_max = 1;
        stall = 6'b000001;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (if_stallreq === 1'b0) found = 1;
            else tick();
        end
        if (found == 0) fail_now("stall_reach_done");
        held_pc = if_pc;
        held_inst = if_inst;
        tick();
`ifdef IF_INST_BUF_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_no_req", 32'(mem_req), 32'd0);
            check("hold_inst", if_inst, held_inst);
            tick();
        end
`else
        @(negedge clk);
        check("refetch_req", 32'(mem_req), 32'd1);
        check("refetch_addr", mem_addr, held_pc);
        tick();
        @(negedge clk);
        check("refetch_done", 32'(if_stallreq), 32'd0);
        check("refetch_pc", if_pc, held_pc);
        check("refetch_inst", if_inst, held_inst);
        tick();
        tick();
`endif
        stall = '0;

        // PC wrap at the top of the address space
        n0 = iss_q.size();
        ex_b_flag = 1'b1;
        ex_b_target = 32'hFFFF_FFFC;
        tick();
        ex_b_flag = 1'b0;
        found = -1;
        for (int i = 0; i < 40 && found < 0; i++) begin
            tick();
            for (int j = n0; j + 1 < iss_q.size(); j++) begin
                if (iss_q[j] == 32'hFFFF_FFFC && found < 0) found = j;
            end
        end
        if (found < 0) fail_now("wrap_issue");
        else check("wrap_addr", iss_at(found + 1), 32'h0000_0000);

        // Randomised traffic: latencies, stalls and redirects
        lat_min = 1;
        lat_max = 4;
        acc0 = n_acc;
        for (int i = 0; i < 600; i++) begin
            stall = {5'($urandom), ($urandom_range(3, 0) == 0)};
            ex_b_flag = ($urandom_range(15, 0) == 0);
            ex_b_target = $urandom;
            tick();
        end
        stall = '0;
        ex_b_flag = 1'b0;
        repeat (10) tick();
        check("random_progress", 32'(n_acc - acc0 > 20), 32'd1);

        // Reset during a read, then a stray ack while idle
        lat_min = 3;
        lat_max = 3;
        wait_new_issue("rst_issue");
        rst = 1'b1;
        @(negedge clk);
        check("rst_drop_req", 32'(mem_req), 32'd0);
        tick();
        rst = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        check("stray_idle_req", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        check("stray_first_req", 32'(mem_req), 32'd1);
        check("stray_first_addr", mem_addr, RESET_PC);
        lat_min = 1;
        lat_max = 2;
        acc0 = n_acc;
        repeat (20) tick();
        check("post_rst_progress", 32'(n_acc - acc0 > 3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
